grid_move_ctrl: RTL and testbench

- Parametrised player-position controller: replaces the fixed 5-bit x/y registers updated directly from the collision logic on every frame tick.
- Buffers decoded keyboard moves in a small FIFO. Applies at most one move per frame tick.
- Bounds-checks the target cell against configurable grid limits, then queries an external map/tile store over a req/ack handshake.
- Commits the new position only when the target tile is not a wall. Sits between move_control/ps2_rx and the renderer/position consumers.

---
 rtl/grid_move_ctrl.sv | 146 ++++++++++++++
 tb/tb_grid_move_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_move_ctrl.sv
// Player-position controller: queues keyboard moves, applies one per frame tick,
// bounds-checks the target cell and asks the tile store whether it is a wall.
module grid_move_ctrl #(
  parameter int COORD_W = 5,
  parameter int MAX_X   = 31,
  parameter int MAX_Y   = 31,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int QDEPTH  = 4,
  parameter int MAP_W   = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       frame_tick,
  input  logic                       move_valid,
  input  logic [2:0]                 move_code,
  input  logic [MAP_W-1:0]           map_sel,
  output logic                       tile_req,
  output logic [COORD_W-1:0]         tile_x,
  output logic [COORD_W-1:0]         tile_y,
  output logic [MAP_W-1:0]           tile_map,
  input  logic                       tile_ack,
  input  logic                       tile_wall,
  output logic [COORD_W-1:0]         x_pos,
  output logic [COORD_W-1:0]         y_pos,
  output logic                       moved,
  output logic                       blocked,
  output logic                       dropped,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic                       busy,
  output logic [1:0]                 fsm_state
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_LOOKUP = 2'd2;

  // Handshake: tile_req rises with stable tile_x/tile_y/tile_map and stays high
  // until the cycle tile_ack is sampled; tile_wall is only meaningful in that cycle.

  logic [1:0]         state;
  logic [2:0]         mem [QDEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [2:0]         mv;
  logic               code_ok;
  logic               push;
  logic               pop;
  logic               full;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               edge_hit;

  assign code_ok   = (move_code >= 3'd1) && (move_code <= 3'd4);
  assign full      = (q_count == CW'(QDEPTH));
  // A pop in the same cycle does not make room: fullness is judged before the pop.
  assign push      = move_valid && code_ok && !full;
  assign pop       = (state == S_IDLE) && frame_tick && (q_count != '0);
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_comb begin
    cand_x   = x_pos;
    cand_y   = y_pos;
    edge_hit = 1'b0;
    case (mv)
      3'd1: if (y_pos == '0) edge_hit = 1'b1;
            else cand_y = y_pos - COORD_W'(1);
      3'd2: if (y_pos == COORD_W'(MAX_Y)) edge_hit = 1'b1;
            else cand_y = y_pos + COORD_W'(1);
      3'd3: if (x_pos == '0) edge_hit = 1'b1;
            else cand_x = x_pos - COORD_W'(1);
      3'd4: if (x_pos == COORD_W'(MAX_X)) edge_hit = 1'b1;
            else cand_x = x_pos + COORD_W'(1);
      default: edge_hit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= move_code;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      mv       <= 3'd0;
      tile_req <= 1'b0;
      tile_x   <= '0;
      tile_y   <= '0;
      tile_map <= '0;
      x_pos    <= COORD_W'(START_X);
      y_pos    <= COORD_W'(START_Y);
      moved    <= 1'b0;
      blocked  <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      moved   <= 1'b0;
      blocked <= 1'b0;
      dropped <= move_valid && code_ok && full;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_count <= q_count + CW'(push) - CW'(pop);
      case (state)
        S_IDLE: begin
          if (pop) begin
            mv    <= mem[rd_ptr];
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (edge_hit) begin
            blocked <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tile_x   <= cand_x;
            tile_y   <= cand_y;
            tile_map <= map_sel;
            tile_req <= 1'b1;
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (tile_ack) begin
            tile_req <= 1'b0;
            state    <= S_IDLE;
            if (tile_wall) begin
              blocked <= 1'b1;
            end else begin
              x_pos <= tile_x;
              y_pos <= tile_y;
              moved <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_move_ctrl.sv
// Bench for grid_move_ctrl: a small position/FIFO model pushes expected
// moved/blocked/dropped events; a negedge monitor pops and compares them.
module tb_grid_move_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       move_valid;
  logic [2:0] move_code;
  logic [1:0] map_sel;
  logic       tile_req;
  logic [4:0] tile_x;
  logic [4:0] tile_y;
  logic [1:0] tile_map;
  logic       tile_ack;
  logic       tile_wall;
  logic [4:0] x_pos;
  logic [4:0] y_pos;
  logic       moved;
  logic       blocked;
  logic       dropped;
  logic [2:0] q_count;
  logic       busy;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // Event word: {moved, blocked, dropped, x, y}
  logic [12:0] exp_q[$];
  logic [2:0]  mq[$];
  int          mcnt;
  logic [4:0]  mx;
  logic [4:0]  my;

  grid_move_ctrl dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .move_valid(move_valid), .move_code(move_code), .map_sel(map_sel),
    .tile_req(tile_req), .tile_x(tile_x), .tile_y(tile_y), .tile_map(tile_map),
    .tile_ack(tile_ack), .tile_wall(tile_wall), .x_pos(x_pos), .y_pos(y_pos),
    .moved(moved), .blocked(blocked), .dropped(dropped), .q_count(q_count),
    .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] ev(input logic [2:0] kind, input logic [4:0] x, input logic [4:0] y);
    return {kind, x, y};
  endfunction

  always @(negedge clk) begin
    if (resetn && (moved || blocked || dropped)) begin
      if (exp_q.size() == 0) check("unexpected_event", 32'({moved, blocked, dropped, x_pos, y_pos}), 32'(0));
      else check("event", 32'({moved, blocked, dropped, x_pos, y_pos}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; frame_tick = 1'b0; move_valid = 1'b0; move_code = 3'd0;
    map_sel = 2'd0; tile_ack = 1'b0; tile_wall = 1'b0;
    mq.delete(); mcnt = 0; mx = 5'd1; my = 5'd1;
    repeat (2) step();
    check("rst_x", 32'(x_pos), 32'(1));
    check("rst_y", 32'(y_pos), 32'(1));
    check("rst_qcount", 32'(q_count), 32'(0));
    check("rst_outs", 32'({tile_req, tile_x, tile_y, tile_map, moved, blocked, dropped, busy}), 32'(0));
    resetn = 1'b1;
    step();
  endtask

  task automatic push_move(input logic [2:0] c);
    move_valid = 1'b1;
    move_code  = c;
    if (c >= 3'd1 && c <= 3'd4) begin
      if (mcnt < 4) begin
        mcnt++;
        mq.push_back(c);
      end else begin
        exp_q.push_back(ev(3'b001, mx, my));
      end
    end
    step();
    move_valid = 1'b0;
    move_code  = 3'd0;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    if (mcnt > 0) mcnt--;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !tile_req; i++) step();
    check("req_seen", 32'(tile_req), 32'(1));
  endtask

  // Model of one applied move: candidate, bounds, wall, new position.
  task automatic expect_outcome(input logic wall, output logic [4:0] cx, output logic [4:0] cy);
    logic [2:0] c;
    logic hit;
    c = mq.pop_front();
    cx = mx; cy = my; hit = 1'b0;
    case (c)
      3'd1: if (my == 5'd0) hit = 1'b1; else cy = my - 5'd1;
      3'd2: if (my == 5'd31) hit = 1'b1; else cy = my + 5'd1;
      3'd3: if (mx == 5'd0) hit = 1'b1; else cx = mx - 5'd1;
      default: if (mx == 5'd31) hit = 1'b1; else cx = mx + 5'd1;
    endcase
    if (hit || wall) exp_q.push_back(ev(3'b010, mx, my));
    else begin
      mx = cx; my = cy;
      exp_q.push_back(ev(3'b100, mx, my));
    end
  endtask

  task automatic ack(input logic wall);
    tile_ack = 1'b1; tile_wall = wall;
    step();
    tile_ack = 1'b0; tile_wall = 1'b0;
    step();
  endtask

  task automatic do_move(input logic [2:0] c);
    logic [4:0] cx, cy;
    push_move(c);
    frame();
    wait_req();
    expect_outcome(1'b0, cx, cy);
    check("mv_tile_x", 32'(tile_x), 32'(cx));
    check("mv_tile_y", 32'(tile_y), 32'(cy));
    ack(1'b0);
  endtask

  initial begin
    logic [4:0] cx, cy;
    do_reset();

    // Single move right, committed on a clear tile.
    push_move(3'd4);
    check("t1_qcount_1", 32'(q_count), 32'(1));
    frame();
    check("t1_busy", 32'(busy), 32'(1));
    wait_req();
    check("t1_tile_x", 32'(tile_x), 32'(2));
    check("t1_tile_y", 32'(tile_y), 32'(1));
    check("t1_tile_map", 32'(tile_map), 32'(0));
    expect_outcome(1'b0, cx, cy);
    ack(1'b0);
    check("t1_x", 32'(x_pos), 32'(2));
    check("t1_y", 32'(y_pos), 32'(1));
    check("t1_qcount_0", 32'(q_count), 32'(0));
    check("t1_req_low", 32'(tile_req), 32'(0));

    // Two lefts from (1,1): second hits x=0 edge, no lookup, no wrap.
    do_reset();
    push_move(3'd3);
    push_move(3'd3);
    frame();
    wait_req();
    check("t2_tile_x", 32'(tile_x), 32'(0));
    expect_outcome(1'b0, cx, cy);
    ack(1'b0);
    expect_outcome(1'b0, cx, cy);
    frame();
    for (int i = 0; i < 4; i++) begin
      check("t2_no_req", 32'(tile_req), 32'(0));
      tile_ack = (i == 2);
      step();
    end
    tile_ack = 1'b0;
    check("t2_x", 32'(x_pos), 32'(0));
    check("t2_y", 32'(y_pos), 32'(1));

    // Down into a wall with a slow ack and map_sel toggling.
    map_sel = 2'd1;
    push_move(3'd2);
    frame();
    wait_req();
    for (int i = 0; i < 10; i++) begin
      map_sel = 2'($urandom_range(0, 3));
      step();
      check("t3_req_hold", 32'({tile_req, tile_x, tile_y, tile_map}), 32'({1'b1, 5'd0, 5'd2, 2'd1}));
    end
    expect_outcome(1'b1, cx, cy);
    ack(1'b1);
    check("t3_y", 32'(y_pos), 32'(1));
    check("t3_x", 32'(x_pos), 32'(0));

    // Fill the FIFO, overflow once, then push non-move codes.
    push_move(3'd1);
    push_move(3'd2);
    push_move(3'd3);
    push_move(3'd4);
    push_move(3'd4);
    step();
    check("t4_qcount_full", 32'(q_count), 32'(4));
    push_move(3'd0);
    push_move(3'd7);
    push_move(3'd5);
    step();
    check("t4_qcount_same", 32'(q_count), 32'(4));

    // Extra frame ticks during LOOKUP are neither applied nor remembered.
    frame();
    wait_req();
    check("t5_tile_y", 32'(tile_y), 32'(0));
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
    check("t5_qcount_3", 32'(q_count), 32'(3));
    expect_outcome(1'b0, cx, cy);
    ack(1'b0);
    repeat (4) begin
      check("t5_idle_req", 32'({tile_req, busy}), 32'(0));
      step();
    end
    check("t5_qcount_after", 32'(q_count), 32'(3));
    check("t5_pos", 32'({x_pos, y_pos}), 32'({5'd0, 5'd0}));

    // Walk to (5,5), start a lookup, then reset mid-request.
    do_reset();
    for (int i = 0; i < 4; i++) do_move(3'd4);
    for (int i = 0; i < 4; i++) do_move(3'd2);
    check("t6_pos", 32'({x_pos, y_pos}), 32'({5'd5, 5'd5}));
    push_move(3'd4);
    push_move(3'd2);
    frame();
    wait_req();
    resetn = 1'b0;
    #2;
    check("t6_req_drop", 32'(tile_req), 32'(0));
    check("t6_pos_rst", 32'({x_pos, y_pos}), 32'({5'd1, 5'd1}));
    check("t6_q_busy", 32'({q_count, busy}), 32'(0));
    step();
    resetn = 1'b1;
    step();

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
